// File: rtl/dkong_pkg.sv
// dkong_pkg: shared DMA state encoding, default sprite-copy window and the Z80 bus bundle types
// used by the Donkey Kong sprite DMA controller.
package dkong_pkg;

    localparam logic [15:0] DKONG_SRC_BASE = 16'h6900;
    localparam logic [15:0] DKONG_DST_BASE = 16'h7000;
    localparam int          DKONG_XFER_LEN = 384;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        WR,
        REL
    } dma_state_t;

    // Master side of the Z80 bus as seen by the system multiplexer; strobes are active-low.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        rdn;
        logic        wrn;
        logic        inta;
    } Z80MasterBus;

    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } Z80SlaveBus;

endpackage

// File: rtl/dkong_dma_ctrl.sv
// dkong_dma_ctrl: vblank-triggered sprite DMA copying XFER_LEN bytes from work RAM to object RAM.
// Define DKONG_DMA_ABORT_EN to let dma_rdy=0 end a running transfer after the current access.
module dkong_dma_ctrl
    import dkong_pkg::*;
#(
    parameter logic [15:0] SRC_BASE = DKONG_SRC_BASE,
    parameter logic [15:0] DST_BASE = DKONG_DST_BASE,
    parameter int          XFER_LEN = DKONG_XFER_LEN
) (
    input  logic        masterclk,
    input  logic        rst_n,
    input  logic        dma_rdy,
    input  logic        vblk,
    input  logic        busak_n,
    output logic        busrq_n,
    output logic        msel,
    output logic        mreq_n,
    output Z80MasterBus dma_bus,
    input  Z80SlaveBus  sbus,
    output logic        busy
);

    localparam logic [9:0] LAST_IDX = 10'(XFER_LEN - 1);

    dma_state_t state;
    dma_state_t state_d;
    logic       vblk_q;
    logic       vblk_rise;
    logic       pending;
    logic       pending_d;
    logic [9:0] idx;
    logic [9:0] idx_d;
    logic [7:0] hold;
    logic [7:0] hold_d;
    logic       acc_first;
    logic       acc_first_d;
    logic       acc_end;
    logic       abort_hit;

    assign vblk_rise = vblk & ~vblk_q;
    // An access is at least two cycles long; the slave may stretch it from the second cycle on.
    assign acc_end   = ~acc_first & sbus.mwait;

`ifdef DKONG_DMA_ABORT_EN
    logic abort_q;

    assign abort_hit = abort_q | ~dma_rdy;

    always_ff @(posedge masterclk) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
        end else if (state == RD || state == WR) begin
            if (!dma_rdy) begin
                abort_q <= 1'b1;
            end
        end else begin
            abort_q <= 1'b0;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge masterclk) begin
        vblk_q <= vblk;
    end

    always_ff @(posedge masterclk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            idx       <= '0;
            hold      <= '0;
            acc_first <= 1'b1;
        end else begin
            state     <= state_d;
            pending   <= pending_d;
            idx       <= idx_d;
            hold      <= hold_d;
            acc_first <= acc_first_d;
        end
    end

    always_comb begin
        state_d     = state;
        pending_d   = pending;
        idx_d       = idx;
        hold_d      = hold;
        acc_first_d = acc_first;

        // Edges arriving while a transfer is running are dropped, not queued.
        if (vblk_rise && dma_rdy && state == IDLE) begin
            pending_d = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (pending) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
                    idx_d     = '0;
                end
            end
            REQ: begin
                if (!dma_rdy) begin
                    state_d = IDLE;
                end else if (!busak_n) begin
                    state_d     = RD;
                    acc_first_d = 1'b1;
                end
            end
            RD: begin
                acc_first_d = 1'b0;
                if (acc_end) begin
                    hold_d      = sbus.dslave;
                    acc_first_d = 1'b1;
                    state_d     = abort_hit ? REL : WR;
                end
            end
            WR: begin
                acc_first_d = 1'b0;
                if (acc_end) begin
                    idx_d       = idx + 10'd1;
                    acc_first_d = 1'b1;
                    if (idx == LAST_IDX || abort_hit) begin
                        state_d = REL;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            REL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs decode straight from the state register so RD and WR can never overlap.
    always_comb begin
        busy            = (state != IDLE);
        msel            = (state == RD) || (state == WR);
        busrq_n         = !((state == REQ) || msel);
        mreq_n          = !msel;
        dma_bus.rdn     = (state != RD);
        dma_bus.wrn     = (state != WR);
        dma_bus.inta    = 1'b1;
        dma_bus.dmaster = hold;
        dma_bus.addr    = (state == WR) ? (DST_BASE + {6'd0, idx})
                                        : (SRC_BASE + {6'd0, idx});
    end

endmodule
